// File: rtl/nx_stat_counter_bank.sv
// nx_stat_counter_bank: live event counters with a stable snapshot array
// and a sweep clear; the snapshot feeds the register indirect-access block.
module nx_stat_counter_bank #(
  parameter int N_ENTRIES   = 32,
  parameter int N_DATA_BITS = 64,
  parameter int N_INC_BITS  = 8,
  parameter int SATURATE    = 1,
  localparam int AW = $clog2(N_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ev_vld,
  input  logic [AW-1:0]          ev_idx,
  input  logic [N_INC_BITS-1:0]  ev_inc,
  input  logic                   clr_one_vld,
  input  logic [AW-1:0]          clr_one_idx,
  input  logic                   clr_all,
  input  logic                   snap_req,
  output logic [N_DATA_BITS-1:0] mem_a [N_ENTRIES],
  output logic [N_ENTRIES-1:0]   ovf,
  output logic                   clr_busy,
  output logic                   snap_done
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  logic snap_pend_q;
  logic snap_pend_d;
  logic snap_take;

  logic [N_DATA_BITS-1:0] live [N_ENTRIES];
  logic [N_DATA_BITS-1:0] snap [N_ENTRIES];
  logic [N_ENTRIES-1:0]   ovf_q;

  logic [N_DATA_BITS:0]   ev_sum;
  logic [N_DATA_BITS-1:0] ev_val;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clr_all) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == AW'(N_ENTRIES - 1)) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // One shared adder: only the addressed counter can change per cycle.
  always_comb begin
    ev_sum = {1'b0, live[ev_idx]}
           + (N_DATA_BITS + 1)'(ev_inc);
    ev_val = ev_sum[N_DATA_BITS-1:0];
    if (ev_sum[N_DATA_BITS] && (SATURATE != 0)) begin
      ev_val = '1;
    end
  end

  // A request during the sweep is held and served on the first idle cycle.
  assign snap_take   = (state_q == IDLE)
                     && (snap_req || snap_pend_q);
  assign snap_pend_d = (state_q == CLEAR)
                     && (snap_pend_q || snap_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      snap_pend_q <= 1'b0;
      snap_done   <= 1'b0;
      ovf_q       <= '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
        live[i] <= '0;
        snap[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      snap_pend_q <= snap_pend_d;
      snap_done   <= snap_take;
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (((state_q == CLEAR) && (ptr_q == AW'(i)))
            || (clr_one_vld && (clr_one_idx == AW'(i)))) begin
          live[i]  <= '0;
          ovf_q[i] <= 1'b0;
        end else if (ev_vld && (ev_idx == AW'(i))) begin
          live[i] <= ev_val;
          if (ev_sum[N_DATA_BITS]) begin
            ovf_q[i] <= 1'b1;
          end
        end
        if (snap_take) begin
          snap[i] <= live[i];
        end
      end
    end
  end

  assign mem_a    = snap;
  assign ovf      = ovf_q;
  assign clr_busy = (state_q == CLEAR);

endmodule

// File: tb/tb_nx_stat_counter_bank.sv
// Bench for nx_stat_counter_bank: saturating and wrapping instances
// share stimulus; snapshots are scored against a queue of expectations.
module tb_nx_stat_counter_bank;

  localparam int NE = 32;
  localparam int DW = 16;
  localparam int IW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          ev_vld;
  logic [AW-1:0] ev_idx;
  logic [IW-1:0] ev_inc;
  logic          clr_one_vld;
  logic [AW-1:0] clr_one_idx;
  logic          clr_all;
  logic          snap_req;

  logic [DW-1:0] mem_s [NE];
  logic [DW-1:0] mem_w [NE];
  logic [NE-1:0] ovf_s, ovf_w;
  logic          busy_s, busy_w;
  logic          done_s, done_w;

  typedef logic [NE-1:0][DW-1:0] arr_t;

  arr_t          m_s, m_w;
  arr_t          e_s, e_w;
  arr_t          q_s[$];
  arr_t          q_w[$];
  logic [NE-1:0] mo_s, mo_w;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  nx_stat_counter_bank #(
    .N_ENTRIES(NE), .N_DATA_BITS(DW),
    .N_INC_BITS(IW), .SATURATE(1)
  ) u_sat (
    .clk(clk), .reset(reset),
    .ev_vld(ev_vld), .ev_idx(ev_idx), .ev_inc(ev_inc),
    .clr_one_vld(clr_one_vld), .clr_one_idx(clr_one_idx),
    .clr_all(clr_all), .snap_req(snap_req),
    .mem_a(mem_s), .ovf(ovf_s),
    .clr_busy(busy_s), .snap_done(done_s)
  );

  nx_stat_counter_bank #(
    .N_ENTRIES(NE), .N_DATA_BITS(DW),
    .N_INC_BITS(IW), .SATURATE(0)
  ) u_wrap (
    .clk(clk), .reset(reset),
    .ev_vld(ev_vld), .ev_idx(ev_idx), .ev_inc(ev_inc),
    .clr_one_vld(clr_one_vld), .clr_one_idx(clr_one_idx),
    .clr_all(clr_all), .snap_req(snap_req),
    .mem_a(mem_w), .ovf(ovf_w),
    .clr_busy(busy_w), .snap_done(done_w)
  );

  task automatic check_eq(string tag, logic [63:0] got,
                          logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic idle();
    ev_vld      = 1'b0;
    ev_idx      = '0;
    ev_inc      = '0;
    clr_one_vld = 1'b0;
    clr_one_idx = '0;
    clr_all     = 1'b0;
    snap_req    = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_ev(int idx, int inc);
    logic [DW:0] s;
    s = {1'b0, m_s[idx]} + (DW + 1)'(inc);
    m_s[idx] = s[DW] ? {DW{1'b1}} : s[DW-1:0];
    if (s[DW]) mo_s[idx] = 1'b1;
    s = {1'b0, m_w[idx]} + (DW + 1)'(inc);
    m_w[idx] = s[DW-1:0];
    if (s[DW]) mo_w[idx] = 1'b1;
  endtask

  task automatic ev(int idx, int inc);
    idle();
    ev_vld = 1'b1;
    ev_idx = AW'(idx);
    ev_inc = IW'(inc);
    model_ev(idx, inc);
    tick();
    idle();
  endtask

  task automatic clr1(int idx);
    idle();
    clr_one_vld = 1'b1;
    clr_one_idx = AW'(idx);
    m_s[idx] = '0;
    m_w[idx] = '0;
    mo_s[idx] = 1'b0;
    mo_w[idx] = 1'b0;
    tick();
    idle();
  endtask

  task automatic snap();
    idle();
    snap_req = 1'b1;
    q_s.push_back(m_s);
    q_w.push_back(m_w);
    tick();
    idle();
    check_eq("snap_done_s", done_s, 1);
    check_eq("snap_done_w", done_w, 1);
    tick();
    check_eq("snap_done_pulse", done_s, 0);
  endtask

  task automatic chk_ovf(string tag);
    check_eq({tag, "_ovf_s"}, ovf_s, mo_s);
    check_eq({tag, "_ovf_w"}, ovf_w, mo_w);
  endtask

  task automatic chk_all_zero(string tag);
    for (int i = 0; i < NE; i++) begin
      check_eq($sformatf("%s_s[%0d]", tag, i), mem_s[i], 0);
      check_eq($sformatf("%s_w[%0d]", tag, i), mem_w[i], 0);
    end
    check_eq({tag, "_ovf_s"}, ovf_s, 0);
    check_eq({tag, "_ovf_w"}, ovf_w, 0);
    check_eq({tag, "_busy"}, busy_s, 0);
    check_eq({tag, "_done"}, done_s, 0);
  endtask

  // Scoreboard: every snap_done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && done_s) begin
      if (q_s.size() == 0) begin
        check_eq("snap_s_unexpected", done_s, 0);
      end else begin
        e_s = q_s.pop_front();
        for (int i = 0; i < NE; i++)
          check_eq($sformatf("mem_s[%0d]", i), mem_s[i], e_s[i]);
      end
    end
    if (!reset && done_w) begin
      if (q_w.size() == 0) begin
        check_eq("snap_w_unexpected", done_w, 0);
      end else begin
        e_w = q_w.pop_front();
        for (int i = 0; i < NE; i++)
          check_eq($sformatf("mem_w[%0d]", i), mem_w[i], e_w[i]);
      end
    end
  end

  initial begin
    idle();
    reset = 1'b1;
    m_s = '0;
    m_w = '0;
    mo_s = '0;
    mo_w = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk_all_zero("rst");

    // basic increments
    repeat (4) ev(3, 5);
    snap();
    check_eq("inc_mem3", mem_s[3], 20);
    chk_ovf("inc");

    // saturation versus wrap on idx 7
    repeat (256) ev(7, 255);
    ev(7, 253);
    snap();
    check_eq("pre_sat7", mem_s[7], 16'hfffd);
    ev(7, 10);
    chk_ovf("sat");
    check_eq("sat_ovf7", ovf_s[7], 1);
    snap();
    check_eq("sat_mem7", mem_s[7], 16'hffff);
    check_eq("wrap_mem7", mem_w[7], 7);
    clr1(7);
    chk_ovf("clr7");
    snap();
    check_eq("clr_mem7", mem_s[7], 0);

    // wrap on idx 0 from all-ones
    repeat (257) ev(0, 255);
    ev(0, 2);
    snap();
    check_eq("wrap_mem0", mem_w[0], 1);
    check_eq("wrap_ovf0", ovf_w[0], 1);
    check_eq("sat_mem0", mem_s[0], 16'hffff);

    // clear beats event on the same index
    ev(4, 50);
    idle();
    ev_vld = 1'b1;
    ev_idx = AW'(4);
    ev_inc = IW'(9);
    clr_one_vld = 1'b1;
    clr_one_idx = AW'(4);
    m_s[4] = '0;
    m_w[4] = '0;
    tick();
    idle();
    // snapshot sees the old value, live takes the event
    snap_req = 1'b1;
    ev_vld = 1'b1;
    ev_idx = AW'(5);
    ev_inc = IW'(3);
    q_s.push_back(m_s);
    q_w.push_back(m_w);
    model_ev(5, 3);
    tick();
    idle();
    check_eq("same_cyc_done", done_s, 1);
    check_eq("same_cyc_old5", mem_s[5], 0);
    tick();
    snap();
    check_eq("coll_mem4", mem_s[4], 0);
    check_eq("new_mem5", mem_s[5], 3);

    // sweep with traffic and a deferred snapshot
    for (int i = 0; i < NE; i++) ev(i, 100);
    idle();
    clr_all = 1'b1;
    tick();
    for (int t = 1; t <= 35; t++) begin
      check_eq($sformatf("sw_busy_s@%0d", t), busy_s, (t <= 32));
      check_eq($sformatf("sw_busy_w@%0d", t), busy_w, (t <= 32));
      check_eq($sformatf("sw_done@%0d", t), done_s, (t == 34));
      idle();
      if (t == 3) begin
        ev_vld = 1'b1;
        ev_idx = AW'(0);
        ev_inc = IW'(1);
      end
      if (t == 5) begin
        ev_vld = 1'b1;
        ev_idx = AW'(20);
        ev_inc = IW'(1);
      end
      if (t == 10) begin
        snap_req = 1'b1;
        m_s = '0;
        m_w = '0;
        m_s[0] = 1;
        m_w[0] = 1;
        mo_s = '0;
        mo_w = '0;
        q_s.push_back(m_s);
        q_w.push_back(m_w);
      end
      if (t == 15) clr_all = 1'b1;
      tick();
    end
    idle();
    check_eq("sw_mem0", mem_s[0], 1);
    check_eq("sw_mem20", mem_s[20], 0);
    chk_ovf("sw");

    // reset mid-sweep with a pending snapshot
    ev(9, 77);
    snap();
    clr_all = 1'b1;
    tick();
    for (int t = 1; t < 10; t++) begin
      idle();
      if (t == 5) snap_req = 1'b1;
      tick();
    end
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_s = '0;
    m_w = '0;
    mo_s = '0;
    mo_w = '0;
    chk_all_zero("rst_mid");
    for (int t = 0; t < 40; t++) begin
      check_eq($sformatf("post_rst_done@%0d", t), done_s | done_w, 0);
      check_eq($sformatf("post_rst_busy@%0d", t), busy_s | busy_w, 0);
      tick();
    end

    check_eq("q_s_empty", q_s.size(), 0);
    check_eq("q_w_empty", q_w.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
